pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have one clock and an active-low asynchronous reset.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 load_use_stall  in  1  load-use request from the interlock (lw in DX feeding a decode operand).
REQ-005 dx_opcode  in  5  opcode field of the DX instruction, IR[31:27].
REQ-006 dx_aluop  in  5  ALU-op field of the DX instruction, IR[6:2].
REQ-007 branch_taken  in  1  execute-stage redirect (taken branch, j, jal, jr, bex).
REQ-008 md_result_rdy  in  1  multdiv result-ready pulse.
REQ-009 pc_en, fd_en, dx_en  out  1 each  latch write enables.
REQ-010 fd_flush  out  1  load nop into FD.
REQ-011 dx_bubble  out  1  load nop into DX.
REQ-012 md_start_mult, md_start_div  out  1 each  one-cycle multdiv start pulses.
REQ-013 md_busy  out  1  multdiv operation in flight.
REQ-014 md_timeout  out  1  sticky error flag.
REQ-015 stall_count  out  32  saturating count of cycles with pc_en=0.

Function
REQ-016 Multdiv detect: dx_is_md = dx_opcode==00000 and dx_aluop in {00110 mul, 00111 div}.
REQ-017 FSM states: IDLE, MD_WAIT.
REQ-018 IDLE with dx_is_md: assert md_start_mult (mul) or md_start_div (div) combinationally for exactly that cycle; pc_en=fd_en=dx_en=0; next state MD_WAIT.
REQ-019 MD_WAIT without md_result_rdy: pc_en=fd_en=dx_en=0, md_busy=1, no start pulse, stay.
REQ-020 MD_WAIT with md_result_rdy: pc_en=fd_en=dx_en=1 (multdiv instruction advances to XM with its result); next state IDLE.
REQ-021 Timeout: 6-bit counter clears on entry to MD_WAIT and increments each MD_WAIT cycle; at 63 without md_result_rdy, set md_timeout (sticky until reset), release enables for one cycle, return to IDLE.
REQ-022 Priority (highest first): multdiv stall (REQ-018..021) > branch flush > load-use stall.
REQ-023 Branch flush (IDLE, not dx_is_md, branch_taken=1): pc_en=1, fd_flush=1, dx_bubble=1, fd_en=dx_en=1; a concurrent load_use_stall is ignored.
REQ-024 Load-use (IDLE, no higher event, load_use_stall=1): pc_en=0, fd_en=0, dx_bubble=1, dx_en=1; exactly one bubble per asserted cycle.
REQ-025 Otherwise: pc_en=fd_en=dx_en=1, fd_flush=dx_bubble=0.
REQ-026 Back-to-back multdiv: a second mul/div entering DX on the cycle after REQ-020 SHALL start a new operation.
REQ-027 branch_taken and load_use_stall are ignored in MD_WAIT.
REQ-028 stall_count SHALL increment on every clock edge where pc_en=0 and saturate at 0xFFFFFFFF.

Reset
REQ-029 Reset asserted: state=IDLE, timeout counter=0, md_timeout=0, stall_count=0, md_busy=0, start pulses=0.
REQ-030 Reset asserted mid-MD_WAIT SHALL abandon the operation; no start pulse may be issued in the cycle reset deasserts unless DX holds mul/div.

Structure
REQ-031 Opcode/ALU-op constants (00000, 00110, 00111), state encoding and timeout limit (63) SHALL live in the shared processor constants package.
REQ-032 The saturating stall counter SHALL be a separate sub-module, sat_counter32.

Verification
REQ-033 mul in DX, md_result_rdy on cycle 17 -> md_start_mult for 1 cycle, pc_en=0 cycles 0-16, pc_en=1 cycle 17, stall_count=17.
REQ-034 load_use_stall=1 for one cycle -> pc_en=0, fd_en=0, dx_bubble=1 that cycle; next cycle all enables=1, stall_count=1.
REQ-035 branch_taken=1 and load_use_stall=1 together -> fd_flush=1, dx_bubble=1, pc_en=1, stall_count unchanged.
REQ-036 div in DX, md_result_rdy never -> md_start_div once, enables released on cycle 64, md_timeout=1 thereafter.
REQ-037 reset pulled low during MD_WAIT cycle 5 -> all REQ-029 values immediately, no start pulse on release with a non-md instruction in DX.
REQ-038 mul then div back-to-back, each ready after 3 cycles -> two distinct start pulses separated by 4 cycles.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared processor constants for the stall/flush controller: decode fields,
// FSM encoding and the multdiv watchdog limit.
package pipeline_stall_ctrl_pkg;

   localparam logic [4:0] OPC_ALU   = 5'b00000;
   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MD_WAIT = 1'b1;

   localparam int         MD_CNT_W      = 6;
   localparam logic [5:0] MD_TIMEOUT_LIM = 6'd63;

   function automatic logic isMulDiv(input logic [4:0] opcode, input logic [4:0] aluop);
      return (opcode == OPC_ALU) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter32.sv
// 32-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard controller: multdiv interlock with watchdog, branch flush
// and load-use bubble insertion, plus a saturating stall-cycle counter.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | normal flow; resolves multdiv start > branch flush > load-use
//  ST_MD_WAIT | multdiv in flight; pipeline frozen until ready or watchdog
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_use_stall,
   input  logic [4:0]  dx_opcode,
   input  logic [4:0]  dx_aluop,
   input  logic        branch_taken,
   input  logic        md_result_rdy,
   output logic        pc_en,
   output logic        fd_en,
   output logic        dx_en,
   output logic        fd_flush,
   output logic        dx_bubble,
   output logic        md_start_mult,
   output logic        md_start_div,
   output logic        md_busy,
   output logic        md_timeout,
   output logic [31:0] stall_count
);

   logic [0:0]          state;
   logic [0:0]          nextState;
   logic [MD_CNT_W-1:0] mdCnt;
   logic                dxIsMd;
   logic                timeoutHit;
   logic                startMult;
   logic                startDiv;

   assign dxIsMd = isMulDiv(dx_opcode, dx_aluop);

   always_comb begin
      nextState  = state;
      pc_en      = 1'b1;
      fd_en      = 1'b1;
      dx_en      = 1'b1;
      fd_flush   = 1'b0;
      dx_bubble  = 1'b0;
      startMult  = 1'b0;
      startDiv   = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dxIsMd) begin
               pc_en     = 1'b0;
               fd_en     = 1'b0;
               dx_en     = 1'b0;
               startMult = (dx_aluop == ALUOP_MUL);
               startDiv  = (dx_aluop == ALUOP_DIV);
               nextState = ST_MD_WAIT;
            end else if (branch_taken) begin
               fd_flush  = 1'b1;
               dx_bubble = 1'b1;
            end else if (load_use_stall) begin
               pc_en     = 1'b0;
               fd_en     = 1'b0;
               dx_bubble = 1'b1;
            end
         end
         ST_MD_WAIT: begin
            if (md_result_rdy) begin
               nextState = ST_IDLE;
            end else if (mdCnt == MD_TIMEOUT_LIM) begin
               // Watchdog: let the stuck instruction drain rather than hang the core.
               timeoutHit = 1'b1;
               nextState  = ST_IDLE;
            end else begin
               pc_en = 1'b0;
               fd_en = 1'b0;
               dx_en = 1'b0;
            end
         end
         default: nextState = ST_IDLE;
      endcase
   end

   // Start pulses are decoded from DX combinationally, so mask them while reset is held.
   assign md_start_mult = startMult & rst_n;
   assign md_start_div  = startDiv & rst_n;
   assign md_busy       = (state == ST_MD_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mdCnt      <= '0;
         md_timeout <= 1'b0;
      end else begin
         state <= nextState;
         if (state == ST_IDLE) begin
            mdCnt <= '0;
         end else begin
            mdCnt <= mdCnt + 1'b1;
         end
         if (timeoutHit) begin
            md_timeout <= 1'b1;
         end
      end
   end

   sat_counter32 u_stallCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~pc_en),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_use_stall;
   logic [4:0]  dx_opcode;
   logic [4:0]  dx_aluop;
   logic        branch_taken;
   logic        md_result_rdy;
   logic        pc_en, fd_en, dx_en, fd_flush, dx_bubble;
   logic        md_start_mult, md_start_div, md_busy, md_timeout;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int multCycle, divCycle;

   always #5 clk = ~clk;

   pipeline_stall_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_use_stall (load_use_stall),
      .dx_opcode      (dx_opcode),
      .dx_aluop       (dx_aluop),
      .branch_taken   (branch_taken),
      .md_result_rdy  (md_result_rdy),
      .pc_en          (pc_en),
      .fd_en          (fd_en),
      .dx_en          (dx_en),
      .fd_flush       (fd_flush),
      .dx_bubble      (dx_bubble),
      .md_start_mult  (md_start_mult),
      .md_start_div   (md_start_div),
      .md_busy        (md_busy),
      .md_timeout     (md_timeout),
      .stall_count    (stall_count)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Move to the falling edge, where outputs are sampled.
   task automatic mid();
      #4;
   endtask

   task automatic setIn(input logic lu, input logic [4:0] aop, input logic br, input logic rdy);
      load_use_stall = lu;
      dx_opcode      = 5'b00000;
      dx_aluop       = aop;
      branch_taken   = br;
      md_result_rdy  = rdy;
   endtask

   task automatic chkEn(input string tag, input logic p, input logic f, input logic d,
                        input logic fl, input logic bb);
      chk1({tag, ".pc_en"}, pc_en, p);
      chk1({tag, ".fd_en"}, fd_en, f);
      chk1({tag, ".dx_en"}, dx_en, d);
      chk1({tag, ".fd_flush"}, fd_flush, fl);
      chk1({tag, ".dx_bubble"}, dx_bubble, bb);
   endtask

   localparam logic [4:0] NOP = 5'b00000;
   localparam logic [4:0] MUL = 5'b00110;
   localparam logic [4:0] DIV = 5'b00111;

   initial begin
      rst_n = 1'b0;
      setIn(1'b0, NOP, 1'b0, 1'b0);
      #3;
      chk32("rst.stall_count", stall_count, 32'd0);
      chk1("rst.md_busy", md_busy, 1'b0);
      chk1("rst.md_timeout", md_timeout, 1'b0);
      chk1("rst.start_mult", md_start_mult, 1'b0);
      chk1("rst.start_div", md_start_div, 1'b0);
      cyc(); cyc();
      mid();
      rst_n = 1'b1;

      // Plain flow
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chkEn("idle", 1, 1, 1, 0, 0);

      // Single-cycle load-use
      cyc(); setIn(1'b1, NOP, 1'b0, 1'b0); mid();
      chkEn("lu1", 0, 0, 1, 0, 1);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chkEn("lu1.after", 1, 1, 1, 0, 0);
      chk32("lu1.stall_count", stall_count, 32'd1);

      // Branch beats load-use
      cyc(); setIn(1'b1, NOP, 1'b1, 1'b0); mid();
      chkEn("br+lu", 1, 1, 1, 1, 1);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chk32("br+lu.stall_count", stall_count, 32'd1);

      // Two consecutive load-use cycles: two bubbles
      cyc(); setIn(1'b1, NOP, 1'b0, 1'b0); mid();
      chkEn("lu2a", 0, 0, 1, 0, 1);
      cyc(); mid();
      chkEn("lu2b", 0, 0, 1, 0, 1);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chk32("lu2.stall_count", stall_count, 32'd3);

      // mul, ready on cycle 17; branch/load-use noise during the wait is ignored
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b0); mid();
      chk1("mul.c0.start_mult", md_start_mult, 1'b1);
      chk1("mul.c0.start_div", md_start_div, 1'b0);
      chkEn("mul.c0", 0, 0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) begin
         cyc(); setIn(1'b1, MUL, 1'b1, 1'b0); mid();
         chkEn("mul.wait", 0, 0, 0, 0, 0);
         chk1("mul.wait.busy", md_busy, 1'b1);
         chk1("mul.wait.start_mult", md_start_mult, 1'b0);
      end
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b1); mid();
      chkEn("mul.c17", 1, 1, 1, 0, 0);
      chk1("mul.c17.start_mult", md_start_mult, 1'b0);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chk32("mul.stall_count", stall_count, 32'd20);
      chk1("mul.after.busy", md_busy, 1'b0);
      chkEn("mul.after", 1, 1, 1, 0, 0);

      // mul then div back-to-back, each ready after 3 cycles
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b0); mid();
      chk1("b2b.mul.start", md_start_mult, 1'b1);
      multCycle = cycle;
      cyc(); mid();
      chk1("b2b.mul.w1.start", md_start_mult, 1'b0);
      cyc(); mid();
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b1); mid();
      chk1("b2b.mul.rdy.pc_en", pc_en, 1'b1);
      cyc(); setIn(1'b0, DIV, 1'b0, 1'b0); mid();
      chk1("b2b.div.start", md_start_div, 1'b1);
      chk1("b2b.div.no_mult", md_start_mult, 1'b0);
      divCycle = cycle;
      chk32("b2b.spacing", divCycle - multCycle, 32'd4);
      cyc(); mid();
      cyc(); mid();
      cyc(); setIn(1'b0, DIV, 1'b0, 1'b1); mid();
      chk1("b2b.div.rdy.pc_en", pc_en, 1'b1);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chk32("b2b.stall_count", stall_count, 32'd26);

      // div that never completes: watchdog releases on cycle 64
      cyc(); setIn(1'b0, DIV, 1'b0, 1'b0); mid();
      chk1("to.c0.start_div", md_start_div, 1'b1);
      for (int i = 1; i <= 63; i++) begin
         cyc(); mid();
         chk1("to.wait.pc_en", pc_en, 1'b0);
         chk1("to.wait.start_div", md_start_div, 1'b0);
      end
      cyc(); mid();
      chkEn("to.c64", 1, 1, 1, 0, 0);
      chk1("to.c64.md_timeout", md_timeout, 1'b0);
      chk1("to.c64.start_div", md_start_div, 1'b0);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chk1("to.c65.md_timeout", md_timeout, 1'b1);
      chk1("to.c65.busy", md_busy, 1'b0);
      chk32("to.stall_count", stall_count, 32'd90);
      cyc(); cyc(); mid();
      chk1("to.sticky", md_timeout, 1'b1);

      // Reset during MD_WAIT cycle 5
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b0); mid();
      chk1("rw.c0.start_mult", md_start_mult, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         cyc(); mid();
      end
      cyc();
      chk1("rw.c5.busy_before", md_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("rw.busy", md_busy, 1'b0);
      chk1("rw.md_timeout", md_timeout, 1'b0);
      chk32("rw.stall_count", stall_count, 32'd0);
      chk1("rw.start_mult", md_start_mult, 1'b0);
      chk1("rw.start_div", md_start_div, 1'b0);
      setIn(1'b0, NOP, 1'b0, 1'b0);
      cyc(); mid();
      rst_n = 1'b1;
      #1;
      chk1("rw.rel.start_mult", md_start_mult, 1'b0);
      chk1("rw.rel.start_div", md_start_div, 1'b0);
      cyc(); mid();
      chkEn("rw.rel", 1, 1, 1, 0, 0);
      chk1("rw.rel.busy", md_busy, 1'b0);
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b0); mid();
      chk1("rw.newmul.start", md_start_mult, 1'b1);
      cyc(); setIn(1'b0, MUL, 1'b0, 1'b1); mid();
      chk1("rw.newmul.rdy.pc_en", pc_en, 1'b1);
      cyc(); setIn(1'b0, NOP, 1'b0, 1'b0); mid();
      chk32("rw.newmul.stall_count", stall_count, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
